// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - windowed RGB444 VGA capture into a frame-buffer write port
module vga_capture #(
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_TOTAL = 800,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int X0      = 0,
    parameter int Y0      = 0,
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              pix_en,
    input  logic [3:0]        i_red,
    input  logic [3:0]        i_green,
    input  logic [3:0]        i_blue,
    input  logic              i_hsync,
    input  logic              i_vsync,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              complete,
    output logic              err
);

    localparam int HW = $clog2(2 * H_TOTAL + 1);
    localparam int VW = 16;

    localparam logic [HW-1:0] H_MAX  = HW'(2 * H_TOTAL);
    localparam logic [HW-1:0] X_LO   = HW'(H_SYNC + H_BP + X0);
    localparam logic [HW-1:0] X_LAST = HW'(H_SYNC + H_BP + X0 + IMG_W - 1);
    localparam logic [VW-1:0] Y_LO   = VW'(V_SYNC + V_BP + Y0);
    localparam logic [VW-1:0] Y_LAST = VW'(V_SYNC + V_BP + Y0 + IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    logic        pix_q;
    logic        ld_q;
    logic [11:0] rgb_q;
    logic        hs_q;
    logic        vs_q;
    logic        hs_prev_q;
    logic        vs_prev_q;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          vs_seen_q, vs_seen_d;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_cnt_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [11:0]        wr_data_q;
    logic               busy_q;
    logic               complete_q;
    logic               err_q;

    logic hs_edge;
    logic vs_edge;
    logic in_win;
    logic last_px;
    logic overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q     <= 1'b0;
            ld_q      <= 1'b0;
            rgb_q     <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            pix_q <= pix_en;
            ld_q  <= ld;
            rgb_q <= {i_red, i_green, i_blue};
            hs_q  <= i_hsync;
            vs_q  <= i_vsync;
            if (pix_q) begin
                hs_prev_q <= hs_q;
                vs_prev_q <= vs_q;
            end
        end
    end

    // Edges compare the current sample against the previous strobed sample only.
    assign hs_edge = pix_q & hs_prev_q & ~hs_q;
    assign vs_edge = pix_q & vs_prev_q & ~vs_q;

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        vs_seen_d = vs_seen_q;
        if (pix_q) begin
            if (hs_edge) begin
                h_d       = '0;
                vs_seen_d = 1'b0;
                if (vs_seen_q || vs_edge) begin
                    v_d = '0;
                end else if (v_q != '1) begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                if (h_q != H_MAX) begin
                    h_d = h_q + 1'b1;
                end
                if (vs_edge) begin
                    vs_seen_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q       <= '0;
            v_q       <= '0;
            vs_seen_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            vs_seen_q <= vs_seen_d;
        end
    end

    // Window position is judged on the counter values that belong to this sample.
    assign in_win  = pix_q && (h_d >= X_LO) && (h_d <= X_LAST)
                           && (v_d >= Y_LO) && (v_d <= Y_LAST);
    assign last_px = in_win && (h_d == X_LAST) && (v_d == Y_LAST);
    assign overrun = (h_d == H_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (pix_q) begin
                case (state_q)
                    IDLE: begin
                        if (ld_q) begin
                            state_q <= WAIT_VS;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end
                    end
                    WAIT_VS: begin
                        if (vs_edge) begin
                            state_q    <= CAPTURE;
                            addr_cnt_q <= '0;
                        end
                    end
                    CAPTURE: begin
                        // The final pixel wins over a coincident vsync edge.
                        if (last_px) begin
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= addr_cnt_q;
                            wr_data_q  <= rgb_q;
                            addr_cnt_q <= addr_cnt_q + 1'b1;
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            complete_q <= 1'b1;
                        end else if (vs_edge || overrun) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (in_win) begin
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= addr_cnt_q;
                            wr_data_q  <= rgb_q;
                            addr_cnt_q <= addr_cnt_q + 1'b1;
                        end
                    end
                    DONE: begin
                        if (ld_q) begin
                            state_q    <= WAIT_VS;
                            busy_q     <= 1'b1;
                            complete_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign complete = complete_q;
    assign err      = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed vector bench for vga_capture
module tb_vga_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic        pix_en;
    logic [3:0]  i_red, i_green, i_blue;
    logic        i_hsync, i_vsync;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        busy, complete, err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_capture #(
        .H_SYNC(2), .H_BP(2), .H_TOTAL(12), .V_SYNC(1), .V_BP(1),
        .X0(1), .Y0(0), .IMG_W(4), .IMG_H(3), .ADDR_W(4)
    ) dut (
        .clk(clk), .rst(rst), .ld(ld), .pix_en(pix_en),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .i_hsync(i_hsync), .i_vsync(i_vsync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .complete(complete), .err(err)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [11:0] data;
        int          c;
    } wr_t;

    wr_t wq[$];

    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data, cyc});
    end

    typedef struct {
        bit pre_arm;
        int arm_line;
        int vs_line;
        int vs_h;
        int sup_from;
        int sup_len;
        int exp_writes;
        bit exp_err;
        bit exp_complete;
        bit exp_busy;
    } vec_t;

    logic [11:0] exp_data [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit hs, input bit vs, input logic [3:0] a, input bit l);
        i_hsync = hs;
        i_vsync = vs;
        i_red   = a;
        i_green = a;
        i_blue  = a;
        ld      = l;
        pix_en  = 1'b1;
        @(negedge clk);
    endtask

    // Frame of 6 lines x 12 pixels: line 0 is vsync, pixels 0..1 of each line are hsync.
    task automatic drive_px(input vec_t v, input int p);
        int line;
        int h;
        bit hs;
        bit vs;
        logic [3:0] a;
        line = p / 12;
        h    = p % 12;
        hs   = (h >= 2) || (p >= v.sup_from && p < v.sup_from + v.sup_len);
        vs   = (line != 0) && !(line == v.vs_line && h >= v.vs_h);
        a    = (h >= 4) ? 4'(h - 4) : 4'd0;
        step(hs, vs, a, (line == v.arm_line) && (h < 2));
    endtask

    task automatic pre_idle(input vec_t v, input string tag);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd0, v.pre_arm && (i < 2));
        if (v.pre_arm) begin
            chk({tag, " arm_busy"}, busy, 1);
            chk({tag, " arm_err"}, err, 0);
            chk({tag, " arm_complete"}, complete, 0);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int t0;
        int n;
        int pk;
        wq.delete();
        t0 = cyc;
        pre_idle(v, tag);
        for (int p = 0; p < 72; p++) drive_px(v, p);
        step(1'b1, 1'b1, 4'd0, 1'b0);
        step(1'b1, 1'b1, 4'd0, 1'b0);
        chk({tag, " writes"}, wq.size(), v.exp_writes);
        n = (wq.size() < v.exp_writes) ? wq.size() : v.exp_writes;
        for (int k = 0; k < n; k++) begin
            pk = (2 + k / 4) * 12 + 5 + (k % 4);
            chk($sformatf("%s addr%0d", tag, k), wq[k].addr, k);
            chk($sformatf("%s data%0d", tag, k), wq[k].data, exp_data[k % 4]);
            chk($sformatf("%s lat%0d", tag, k), wq[k].c, t0 + 6 + pk);
        end
        chk({tag, " err"}, err, v.exp_err);
        chk({tag, " complete"}, complete, v.exp_complete);
        chk({tag, " busy"}, busy, v.exp_busy);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        vec_t nv;
        int   rst_hold;
        bit   fired;

        exp_data = '{12'h111, 12'h222, 12'h333, 12'h444};
        vecs[0] = '{1'b0, -1, -1, 0, -1, 0, 12, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0,  5, -1, 0, -1, 0,  0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, -1, -1, 0, -1, 0, 12, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, -1,  3, 8, -1, 0,  7, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, -1, -1, 0, 36, 24, 4, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, -1,  4, 8, -1, 0, 12, 1'b0, 1'b1, 1'b0};
        nv      = '{1'b1, -1, -1, 0, -1, 0, 12, 1'b0, 1'b1, 1'b0};

        rst = 1'b0;
        ld = 1'b0; pix_en = 1'b0;
        i_red = '0; i_green = '0; i_blue = '0; i_hsync = 1'b1; i_vsync = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            i_red   = 4'($urandom);
            i_green = 4'($urandom);
            i_blue  = 4'($urandom);
            i_hsync = 1'($urandom);
            i_vsync = 1'($urandom);
            pix_en  = 1'($urandom);
            ld      = 1'($urandom);
            @(negedge clk);
            chk($sformatf("reset_hold%0d", i), {wr_en, wr_addr, wr_data, busy, complete, err}, 0);
        end

        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd0, 1'b0);
        step(1'b1, 1'b1, 4'd0, 1'b1);
        step(1'b1, 1'b1, 4'd0, 1'b1);
        chk("first_arm_busy", busy, 1);
        step(1'b1, 1'b1, 4'd0, 1'b0);
        chk("first_arm_busy_hold", busy, 1);
        chk("first_arm_complete", complete, 0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        wq.delete();
        fired    = 1'b0;
        rst_hold = 0;
        pre_idle(nv, "rstseq");
        for (int p = 0; p < 72; p++) begin
            drive_px(nv, p);
            if (rst_hold > 0) begin
                chk($sformatf("rst_low_wr_en%0d", rst_hold), wr_en, 0);
                rst_hold--;
                if (rst_hold == 0) rst = 1'b1;
            end
            if (!fired && wq.size() >= 5) begin
                fired = 1'b1;
                rst   = 1'b0;
                #1;
                chk("rst_async_outputs", {wr_en, wr_addr, wr_data, busy, complete, err}, 0);
                rst_hold = 3;
            end
        end
        step(1'b1, 1'b1, 4'd0, 1'b0);
        step(1'b1, 1'b1, 4'd0, 1'b0);
        chk("rst_fired", fired, 1);
        chk("rst_writes", wq.size(), 5);
        chk("rst_busy", busy, 0);
        chk("rst_complete", complete, 0);
        chk("rst_err", err, 0);

        run_frame(nv, "after_rst");
        run_frame(nv, "rearm_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
